// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the mux serialiser controller.
package mux_ctrl_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 4;

    typedef enum logic {IDLE, SEND} ser_state_t;

    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel,
                                                  input logic             msb_first);
        return msb_first ? sel - 1'b1 : sel + 1'b1;
    endfunction

endpackage

// File: rtl/mux_word_fifo.sv
// Synchronous word FIFO with registered occupancy; head word is visible on rdata_o.
module mux_word_fifo
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/mux_ser_ctrl.sv
// Feeds words to an external 4:1 mux and steps its select to produce a framed serial stream,
// checking each mux output bit against the held word.
module mux_ser_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic [DATA_W-1:0]        mux_din,
    output logic [SEL_W-1:0]         mux_sel,
    input  logic                     mux_out,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_bit,
    output logic                     ser_first,
    output logic                     ser_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     mux_err
);

    localparam logic [SEL_W-1:0] START_SEL = MSB_FIRST ? 2'd3 : 2'd0;

    ser_state_t         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               err_q;
    logic               pop, full, empty, exp_bit;
    logic [DATA_W-1:0]  head;

    mux_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        sel_d   = sel_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    din_d   = head;
                    sel_d   = START_SEL;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ser_ready) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 1'b1;
                        sel_d = next_sel(sel_q, MSB_FIRST);
                    end else if (!empty) begin
                        // Chain straight into the next word so the stream has no bubble.
                        pop   = 1'b1;
                        din_d = head;
                        sel_d = START_SEL;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            din_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            sel_q   <= sel_d;
        end
    end

    assign exp_bit = din_q[sel_q];

    // Case inequality so an X from the mux is treated as a mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ser_valid && (mux_out !== exp_bit)) begin
            err_q <= 1'b1;
        end
    end

    assign in_ready  = !full;
    assign mux_din   = din_q;
    assign mux_sel   = sel_q;
    assign ser_valid = (state_q == SEND);
    assign ser_bit   = mux_out;
    assign ser_first = ser_valid && (idx_q == 2'd0);
    assign ser_last  = ser_valid && (idx_q == 2'd3);
    assign busy      = ser_valid || (fifo_count != '0);
    assign mux_err   = err_q;

endmodule
